bcd_seg_scan: RTL and testbench

Four-digit multiplexed seven-segment display driver: the consumer end of the 16-bit packed-BCD bus produced by the team's BCD up/down counter. It snapshots `data` once per frame, so a frame never mixes old and new digits. It then scans the digits one at a time with a dead-time between slots and drives active-low anode and segment lines on the board.

---
 rtl/bcd_seg_scan_if.sv | 24 ++
 rtl/bcd_seg_scan.sv | 116 +++++++++++
 tb/tb_bcd_seg_scan.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bcd_seg_scan_if.sv
// Bus between a display-driver user and the four-digit seven-segment scanner.
// Latency: none, plain wires grouped for port readability.
// Backpressure: none, the scanner is free-running and never stalls its source.
interface bcd_seg_scan_if;
  logic        enable;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  // Source side: supplies digits and display controls, observes the panel lines.
  modport master (
    output enable, data, dp_mask,
    input  an, seg, dp, frame_done
  );

  // Scanner side: consumes digits, drives the active-low panel lines.
  modport slave (
    input  enable, data, dp_mask,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed seven-segment driver with a per-frame tear-free snapshot of packed BCD.
// Latency: outputs registered; the digit shown in slot cycle n reflects state after the edge that entered n.
// Backpressure: none; free-running scan, optional leading-zero blanking via SEG_LZB_EN.
module bcd_seg_scan #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [15:0] DEAD_CYCLES = 16'd100
) (
  input  logic           clk,
  input  logic           reset,
  bcd_seg_scan_if.slave  bus
);

  // ST_IDLE is held during reset so the first edge after release lands on
  // slot cycle 0 of digit 0 (with a snapshot) instead of advancing to cycle 1.
  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  idx, idx_n;
  logic [15:0] frame, frame_n;
  logic        snap;
  logic        lzb_blank;
  logic        blank;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  // Segment patterns {g,f,e,d,c,b,a}, active-low; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Next scan position and snapshot decision; the snapshot fires on the edge entering digit 0 cycle 0.
  always_comb begin
    state_n = ST_SCAN;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    snap    = 1'b0;
    if (state == ST_IDLE) begin
      cnt_n = 16'd0;
      idx_n = 2'd0;
      snap  = 1'b1;
    end else if (cnt == REFRESH_DIV - 16'd1) begin
      cnt_n = 16'd0;
      idx_n = idx + 2'd1;
      snap  = (idx == 2'd3);
    end
    frame_n = snap ? bus.data : frame;
  end

`ifdef SEG_LZB_EN
  // Leading-zero blanking: a digit goes dark when it and every digit to its left are zero.
  always_comb begin
    lzb_blank = 1'b0;
    case (idx_n)
      2'd1:    lzb_blank = (frame_n[15:4]  == 12'h000);
      2'd2:    lzb_blank = (frame_n[15:8]  == 8'h00);
      2'd3:    lzb_blank = (frame_n[15:12] == 4'h0);
      default: lzb_blank = 1'b0;
    endcase
  end
`else
  assign lzb_blank = 1'b0;
`endif

  // Panel line values for the cycle about to start; dead-time, disable and blanking all go dark.
  always_comb begin
    blank = (cnt_n < DEAD_CYCLES) || !bus.enable || lzb_blank;
    an_n  = 4'b1111;
    seg_n = 7'b1111111;
    dp_n  = 1'b1;
    if (!blank) begin
      an_n  = ~(4'b0001 << idx_n);
      seg_n = decode(frame_n[{idx_n, 2'b00} +: 4]);
      dp_n  = ~bus.dp_mask[idx_n];
    end
  end

  // Scan state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= 16'd0;
      idx            <= 2'd0;
      frame          <= 16'h0000;
      bus.an         <= 4'b1111;
      bus.seg        <= 7'b1111111;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      frame          <= frame_n;
      bus.an         <= an_n;
      bus.seg        <= seg_n;
      bus.dp         <= dp_n;
      bus.frame_done <= snap;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with REFRESH_DIV=8, DEAD_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge; cyc 0 is the first edge after reset release.
// Expectations under SEG_LZB_EN differ only in the blanked-digit cases.
module tb_bcd_seg_scan;

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  bcd_seg_scan_if bus();

  bcd_seg_scan #(
    .REFRESH_DIV(16'd8),
    .DEAD_CYCLES(16'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    cyc = -1;
    step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp_v);
    end
  endtask

  logic [6:0] scan_tbl [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b0;
    bus.enable  = 1'b1;
    bus.data    = 16'h1234;
    bus.dp_mask = 4'b0000;

    // Reset held: everything dark, no frame pulse.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_an", {12'h0, bus.an}, 16'h000F);
      chk("rst_seg", {9'h0, bus.seg}, 16'h007F);
      chk("rst_dp", {15'h0, bus.dp}, 16'h0001);
      chk("rst_fd", {15'h0, bus.frame_done}, 16'h0000);
    end
    reset = 1'b1;
    cyc = -1;
    step();

    // Scan order over one frame, with a mid-frame data change that must not tear.
    for (int c = 0; c <= 34; c++) begin
      int d;
      int s;
      d = (c % 32) / 8;
      s = c % 8;
      exp_an  = (s < 2) ? 4'b1111 : ~(4'b0001 << d);
      exp_seg = (s < 2) ? 7'b1111111 : ((c >= 32) ? 7'b0010000 : scan_tbl[d]);
      chk("scan_an", {12'h0, bus.an}, {12'h0, exp_an});
      chk("scan_seg", {9'h0, bus.seg}, {9'h0, exp_seg});
      chk("scan_fd", {15'h0, bus.frame_done}, {15'h0, (c == 0 || c == 32)});
      if (c == 12) bus.data = 16'h9999;
      step();
    end

    // Invalid BCD shows a dash; decimal point only on digit 0.
    bus.data    = 16'h0A0F;
    bus.dp_mask = 4'b0001;
    do_reset();
    for (int c = 0; c <= 31; c++) begin
      chk("dp", {15'h0, bus.dp}, {15'h0, !(c >= 2 && c <= 7)});
      if (c == 2) chk("inv_seg0", {9'h0, bus.seg}, 16'h003F);
      if (c == 18) begin
        chk("inv_an2", {12'h0, bus.an}, 16'h000B);
        chk("inv_seg2", {9'h0, bus.seg}, 16'h003F);
      end
      if (c == 26) chk("inv_an3", {12'h0, bus.an}, LZB ? 16'h000F : 16'h0007);
      step();
    end

    // Leading zeros: 0005.
    bus.data    = 16'h0005;
    bus.dp_mask = 4'b0000;
    do_reset();
    step_to(2);
    chk("lz_an0", {12'h0, bus.an}, 16'h000E);
    chk("lz_seg0", {9'h0, bus.seg}, 16'h0012);
    step_to(10);
    chk("lz_an1", {12'h0, bus.an}, LZB ? 16'h000F : 16'h000D);
    chk("lz_seg1", {9'h0, bus.seg}, LZB ? 16'h007F : 16'h0040);
    step_to(18);
    chk("lz_an2", {12'h0, bus.an}, LZB ? 16'h000F : 16'h000B);
    step_to(26);
    chk("lz_an3", {12'h0, bus.an}, LZB ? 16'h000F : 16'h0007);
    chk("lz_seg3", {9'h0, bus.seg}, LZB ? 16'h007F : 16'h0040);

    // Leading zeros: 0105, only digit 3 may blank.
    bus.data = 16'h0105;
    do_reset();
    step_to(10);
    chk("lz2_an1", {12'h0, bus.an}, 16'h000D);
    chk("lz2_seg1", {9'h0, bus.seg}, 16'h0040);
    step_to(18);
    chk("lz2_an2", {12'h0, bus.an}, 16'h000B);
    chk("lz2_seg2", {9'h0, bus.seg}, 16'h0079);
    step_to(26);
    chk("lz2_an3", {12'h0, bus.an}, LZB ? 16'h000F : 16'h0007);

    // Enable toggling and reset mid-frame.
    bus.data = 16'h1234;
    do_reset();
    step_to(4);
    chk("en_an4", {12'h0, bus.an}, 16'h000E);
    bus.enable = 1'b0;
    step();
    chk("en_an5", {12'h0, bus.an}, 16'h000F);
    step_to(19);
    chk("en_an19", {12'h0, bus.an}, 16'h000F);
    bus.enable = 1'b1;
    step();
    chk("en_an20", {12'h0, bus.an}, 16'h000B);
    chk("en_seg20", {9'h0, bus.seg}, 16'h0024);
    step_to(22);
    reset = 1'b0;
    step();
    chk("mr_an", {12'h0, bus.an}, 16'h000F);
    chk("mr_seg", {9'h0, bus.seg}, 16'h007F);
    chk("mr_dp", {15'h0, bus.dp}, 16'h0001);
    chk("mr_fd", {15'h0, bus.frame_done}, 16'h0000);
    step();
    reset = 1'b1;
    cyc = -1;
    step();
    chk("rs_an0", {12'h0, bus.an}, 16'h000F);
    chk("rs_fd0", {15'h0, bus.frame_done}, 16'h0001);
    step_to(2);
    chk("rs_an2", {12'h0, bus.an}, 16'h000E);
    chk("rs_seg2", {9'h0, bus.seg}, 16'h0019);
    chk("rs_fd2", {15'h0, bus.frame_done}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
